fir_tap_feeder: RTL and testbench

Transmit-side driver for the 33-tap transposed-form FIR datapath. It owns the coefficient bank, written by a host port and presented as a flat bus. It paces 3-bit signed input samples into the filter as an enable strobe plus held sample at a fixed clock-divided rate. On stop it flushes the filter pipeline with zero samples. It sits between the sample source / host control and the FIR multiply-add-shift core.

---
 rtl/fir_tap_feeder.sv | 136 +++++++++++++
 tb/tb_fir_tap_feeder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_feeder.sv
// fir_tap_feeder: coefficient bank plus paced sample strobe for a
// transposed-form FIR core, with a zero-sample flush on stop.
module fir_tap_feeder #(
    parameter int TAPS = 33,
    parameter int DIV  = 4
) (
    input  logic                 iClk_12M,
    input  logic                 iRsn,
    input  logic                 iCoeffWr,
    input  logic [5:0]           iCoeffAddr,
    input  logic [15:0]          iCoeffData,
    input  logic                 iStart,
    input  logic                 iStop,
    input  logic                 iSampleValid,
    input  logic [2:0]           iSample,
    output logic                 oSampleReady,
    output logic [2:0]           oFirIn,
    output logic                 oEnAcc,
    output logic [TAPS*16-1:0]   oCoeffBus,
    output logic                 oBusy,
    output logic                 oCoeffErr,
    output logic                 oUnderrun
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [FW-1:0]       flush_q, flush_d;
    logic [TAPS*16-1:0]  coef_q, coef_d;
    logic [2:0]          fir_in_q, fir_in_d;
    logic                en_acc_q, en_acc_d;
    logic                coeff_err_q, coeff_err_d;
    logic                underrun_q, underrun_d;
    logic                slot;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        coef_d      = coef_q;
        fir_in_d    = fir_in_q;
        en_acc_d    = 1'b0;
        coeff_err_d = coeff_err_q;
        underrun_d  = underrun_q;

        slot         = (cnt_q == CW'(DIV - 1));
        oSampleReady = (state_q == RUN) && slot && !iStop;

        // Bank is writable only while idle; anything else is flagged.
        if (iCoeffWr) begin
            if (state_q == IDLE && int'(iCoeffAddr) < TAPS) begin
                coef_d[16*int'(iCoeffAddr) +: 16] = iCoeffData;
            end else begin
                coeff_err_d = 1'b1;
            end
        end

        if (state_q != IDLE) begin
            cnt_d = slot ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (iStart) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (iStop) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                    flush_d = '0;
                end else if (slot) begin
                    en_acc_d = 1'b1;
                    fir_in_d = iSampleValid ? iSample : 3'd0;
                    if (!iSampleValid) begin
                        underrun_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (slot) begin
                    en_acc_d = 1'b1;
                    fir_in_d = 3'd0;
                    flush_d  = flush_q + 1'b1;
                    if (flush_q == FW'(TAPS - 1)) begin
                        state_d = IDLE;
                        flush_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk_12M) begin
        if (iRsn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            flush_q     <= '0;
            coef_q      <= '0;
            fir_in_q    <= 3'd0;
            en_acc_q    <= 1'b0;
            coeff_err_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            coef_q      <= coef_d;
            fir_in_q    <= fir_in_d;
            en_acc_q    <= en_acc_d;
            coeff_err_q <= coeff_err_d;
            underrun_q  <= underrun_d;
        end
    end

    assign oFirIn    = fir_in_q;
    assign oEnAcc    = en_acc_q;
    assign oCoeffBus = coef_q;
    assign oBusy     = (state_q != IDLE);
    assign oCoeffErr = coeff_err_q;
    assign oUnderrun = underrun_q;

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Randomized bench for fir_tap_feeder against a mode/age reference model.
module tb_fir_tap_feeder;

    localparam int TAPS = 33;
    localparam int DIV  = 4;
    localparam int BW   = TAPS * 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              coeff_wr;
    logic [5:0]        coeff_addr;
    logic [15:0]       coeff_data;
    logic              start;
    logic              stop;
    logic              valid;
    logic [2:0]        sample;
    logic              ready;
    logic [2:0]        fir_in;
    logic              en_acc;
    logic [BW-1:0]     coeff_bus;
    logic              busy;
    logic              coeff_err;
    logic              underrun;

    always #5 clk = ~clk;

    fir_tap_feeder #(.TAPS(TAPS), .DIV(DIV)) dut (
        .iClk_12M     (clk),
        .iRsn         (rst),
        .iCoeffWr     (coeff_wr),
        .iCoeffAddr   (coeff_addr),
        .iCoeffData   (coeff_data),
        .iStart       (start),
        .iStop        (stop),
        .iSampleValid (valid),
        .iSample      (sample),
        .oSampleReady (ready),
        .oFirIn       (fir_in),
        .oEnAcc       (en_acc),
        .oCoeffBus    (coeff_bus),
        .oBusy        (busy),
        .oCoeffErr    (coeff_err),
        .oUnderrun    (underrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [BW-1:0] got,
                         input logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference: mode 0 idle, 1 run, 2 flush; age counts cycles in mode,
    // starting at 1 on the first cycle, so a slot is any age divisible by DIV.
    int          m_mode, m_age, m_flushes;
    logic [15:0] m_coef [TAPS];
    logic [2:0]  m_fir;
    logic        m_en, m_err, m_und, m_acc;

    function automatic logic [BW-1:0] bus_exp();
        logic [BW-1:0] b;
        for (int k = 0; k < TAPS; k++) b[16*k +: 16] = m_coef[k];
        return b;
    endfunction

    function automatic logic exp_ready();
        return m_mode == 1 && (m_age % DIV) == 0 && !stop;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_flushes = 0;
        for (int k = 0; k < TAPS; k++) m_coef[k] = 16'd0;
        m_fir = 3'd0; m_en = 1'b0; m_err = 1'b0; m_und = 1'b0;
    endtask

    task automatic model_edge();
        logic is_slot;
        m_acc = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        is_slot = (m_age % DIV) == 0;
        m_en = 1'b0;
        if (coeff_wr) begin
            if (m_mode == 0 && coeff_addr < TAPS) m_coef[coeff_addr] = coeff_data;
            else m_err = 1'b1;
        end
        case (m_mode)
            0: if (start) begin m_mode = 1; m_age = 1; end
            1: begin
                if (stop) begin
                    m_mode = 2; m_age = 1; m_flushes = 0;
                end else begin
                    if (is_slot) begin
                        m_en  = 1'b1;
                        m_fir = valid ? sample : 3'd0;
                        m_acc = valid;
                        if (!valid) m_und = 1'b1;
                    end
                    m_age++;
                end
            end
            default: begin
                if (is_slot) begin
                    m_en = 1'b1;
                    m_fir = 3'd0;
                    m_flushes++;
                end
                m_age++;
                if (m_flushes == TAPS) begin m_mode = 0; m_flushes = 0; end
            end
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        check("ready", ready, exp_ready());
        check("en_acc", en_acc, m_en);
        check("fir_in", fir_in, m_fir);
        check("busy", busy, m_mode != 0);
        check("coeff_err", coeff_err, m_err);
        check("underrun", underrun, m_und);
        check("coeff_bus", coeff_bus, bus_exp());
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; coeff_wr = 1'b0; coeff_addr = '0; coeff_data = '0;
        start = 1'b0; stop = 1'b0; valid = 1'b0; sample = '0;
    endtask

    task automatic rand_cycle(input int p_wr, input int p_start,
                              input int p_stop, input int p_rst);
        coeff_wr   = ($urandom_range(0, 99) < p_wr);
        coeff_addr = 6'($urandom_range(0, 63));
        coeff_data = 16'($urandom);
        start      = ($urandom_range(0, 99) < p_start);
        stop       = ($urandom_range(0, 99) < p_stop);
        rst        = ($urandom_range(0, 999) < p_rst);
        valid      = ($urandom_range(0, 3) != 0);
        sample     = 3'($urandom);
        cycle();
    endtask

    logic [2:0] pattern [4];
    int idx;

    initial begin
        pattern[0] = 3'd1; pattern[1] = 3'b111;
        pattern[2] = 3'd3; pattern[3] = 3'b100;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();
        rst = 1'b0;
        cycle();

        for (int k = 0; k < TAPS; k++) begin
            coeff_wr = 1'b1; coeff_addr = 6'(k); coeff_data = 16'((k + 1) * 100);
            cycle();
        end
        coeff_addr = 6'd40; coeff_data = 16'hBEEF;
        cycle();
        coeff_wr = 1'b0;
        cycle();
        for (int i = 0; i < 10; i++) rand_cycle(80, 0, 0, 0);
        idle_inputs();
        cycle();

        start = 1'b1;
        cycle();
        start = 1'b0;
        valid = 1'b1;
        idx = 0;
        for (int i = 0; i < 20 && idx < 4; i++) begin
            sample = pattern[idx];
            cycle();
            if (m_acc) idx++;
        end
        check("pattern_done", 32'(idx), 32'd4);
        for (int i = 0; i < 80; i++) rand_cycle(10, 10, 0, 0);

        idle_inputs();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        for (int i = 0; i < 140; i++) rand_cycle(10, 0, 0, 0);
        idle_inputs();
        repeat (3) cycle();

        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 20; i++) rand_cycle(0, 0, 0, 0);
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        start = 1'b1; stop = 1'b1;
        cycle();
        idle_inputs();
        for (int i = 0; i < 30; i++) rand_cycle(0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) rand_cycle(15, 5, 2, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
